// File: rtl/key_event_queue.sv
// Debounces a level-held keycode into press (and, with KEY_REPEAT_EN, auto-repeat) events, released one per frame tick.
// Latency: STABLE_CYC+1 clk from keycode change to FIFO push; a queued event appears on key_out 3 clk after a frame_clk rise.
// Backpressure: none upstream; a push into a full FIFO is dropped and sets the sticky overflow flag.

module key_event_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   push,
    input  logic [W-1:0]           push_dat,
    input  logic                   pop,
    output logic [W-1:0]           head_dat,
    output logic [$clog2(DEPTH):0] count,
    output logic                   drop
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_pop   = pop && (count != '0);
    assign do_push  = push && ((count != (AW+1)'(DEPTH)) || do_pop);
    assign drop     = push && !do_push;
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end
endmodule

module key_event_queue #(
    parameter int STABLE_CYC   = 1024,
    parameter int DEPTH        = 4,
    parameter int REPEAT_DELAY = 30,
    parameter int REPEAT_RATE  = 6
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic [7:0]             keycode,
    input  logic                   frame_clk,
    output logic [7:0]             key_out,
    output logic                   key_valid,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   overflow
);
    if (STABLE_CYC < 1 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0
        || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_params
        $error("key_event_queue: illegal parameter set");
    end

    localparam int SW = $clog2(STABLE_CYC + 1);

    logic [7:0]    cand;
    logic [7:0]    acc;
    logic [SW-1:0] stab_cnt;
    logic          accept;

    assign accept = (stab_cnt == SW'(STABLE_CYC - 1)) && (cand != acc);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cand     <= '0;
            acc      <= '0;
            stab_cnt <= '0;
        end else begin
            cand <= keycode;
            if (keycode != cand)
                stab_cnt <= '0;
            else if (stab_cnt != SW'(STABLE_CYC))
                stab_cnt <= stab_cnt + SW'(1);
            if (accept) acc <= cand;
        end
    end

    logic fs1, fs2, fs3;
    logic tick;

    assign tick = fs2 && !fs3;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            fs1 <= 1'b0;
            fs2 <= 1'b0;
            fs3 <= 1'b0;
        end else begin
            fs1 <= frame_clk;
            fs2 <= fs1;
            fs3 <= fs2;
        end
    end

    logic       push;
    logic [7:0] push_dat;

`ifdef KEY_REPEAT_EN
    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

    localparam int FMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int FW   = $clog2(FMAX + 1);

    state_t        state, state_nxt;
    logic [FW-1:0] fcnt, fcnt_nxt;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            fcnt  <= '0;
        end else begin
            state <= state_nxt;
            fcnt  <= fcnt_nxt;
        end
    end

    // A fresh acceptance outranks a coincident frame tick.
    always_comb begin
        state_nxt = state;
        fcnt_nxt  = fcnt;
        push      = 1'b0;
        push_dat  = acc;
        if (accept) begin
            fcnt_nxt = '0;
            if (cand != 8'h00) begin
                push      = 1'b1;
                push_dat  = cand;
                state_nxt = DELAY;
            end else begin
                state_nxt = IDLE;
            end
        end else if (tick) begin
            case (state)
                DELAY: begin
                    if (fcnt + FW'(1) == FW'(REPEAT_DELAY)) begin
                        push      = 1'b1;
                        state_nxt = REPEAT;
                        fcnt_nxt  = '0;
                    end else begin
                        fcnt_nxt = fcnt + FW'(1);
                    end
                end
                REPEAT: begin
                    if (fcnt + FW'(1) == FW'(REPEAT_RATE)) begin
                        push     = 1'b1;
                        fcnt_nxt = '0;
                    end else begin
                        fcnt_nxt = fcnt + FW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
`else
    typedef enum logic {IDLE, HELD} state_t;

    state_t state, state_nxt;

    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        push_dat  = acc;
        if (accept) begin
            if (cand != 8'h00) begin
                push      = 1'b1;
                push_dat  = cand;
                state_nxt = HELD;
            end else begin
                state_nxt = IDLE;
            end
        end
    end
`endif

    logic [7:0] head_dat;
    logic       drop;

    key_event_fifo #(
        .W     (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .Clk      (Clk),
        .Reset    (Reset),
        .push     (push),
        .push_dat (push_dat),
        .pop      (tick),
        .head_dat (head_dat),
        .count    (fifo_count),
        .drop     (drop)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            key_out   <= 8'h00;
            key_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (tick) begin
                if (fifo_count != '0) begin
                    key_out   <= head_dat;
                    key_valid <= 1'b1;
                end else begin
                    key_out   <= 8'h00;
                    key_valid <= 1'b0;
                end
            end
            if (drop) overflow <= 1'b1;
        end
    end
endmodule
